// File: rtl/conv_pkg.sv
// Shared constants for the convolution datapath and the window feeder.
package conv_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_KERNEL_SIZE = 3;
    localparam int DEFAULT_IMG_WIDTH   = 224;
    localparam int DEFAULT_IMG_HEIGHT  = 224;

    // Width of a counter/address covering 0..n-1. Never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_COL_WIDTH = ctr_width(DEFAULT_IMG_WIDTH);
    localparam int DEFAULT_ROW_WIDTH = ctr_width(DEFAULT_IMG_HEIGHT);

    // FILL: the line buffers are still loading, no window can be complete yet.
    // RUN:  every accept with col >= K-1 completes a window.
    typedef enum logic {
        PHASE_FILL = 1'b0,
        PHASE_RUN  = 1'b1
    } phase_t;

endpackage

// File: rtl/feeder_line_buffer.sv
// One image row of pixel storage, addressed by column. The read port is
// asynchronous, so a read and a write at the same address in the same cycle
// return the old contents while the new pixel is stored at the clock edge.
// Contents are intentionally never cleared.
module feeder_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_IMG_WIDTH,
    parameter int ADDR_WIDTH = ctr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    // Store the incoming pixel at its column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Turns a raster-scan pixel stream into the flattened KxK windows consumed by
// the convolution unit. K-1 cascaded line buffers supply the older rows of the
// incoming column; a KxK shift window slides one column per accepted pixel, and
// a one-deep output register holds each completed window for the consumer.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
    parameter int IMG_WIDTH   = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEFAULT_IMG_HEIGHT,
    localparam int COL_WIDTH  = ctr_width(IMG_WIDTH),
    localparam int ROW_WIDTH  = ctr_width(IMG_HEIGHT),
    localparam int WIN_WIDTH  = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [WIN_WIDTH-1:0]  win_out,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [ROW_WIDTH-1:0]  win_row,
    output logic [COL_WIDTH-1:0]  win_col,
    output logic                  frame_done
);

    // Handshake: a transfer happens on a side exactly when its valid and ready
    // are both high at the rising clock edge. Valid never waits on ready; the
    // input side is ready whenever the output register is free or is being
    // emptied in the same cycle, so one pixel per cycle flows with win_ready high.

    localparam logic [COL_WIDTH-1:0] COL_FIRST = COL_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [COL_WIDTH-1:0] COL_LAST  = COL_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_FIRST = ROW_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST  = ROW_WIDTH'(IMG_HEIGHT - 1);

    logic [COL_WIDTH-1:0]  col;
    logic [ROW_WIDTH-1:0]  row;
    logic                  accept;
    logic                  emit;
    phase_t                phase;

    logic [DATA_WIDTH-1:0] lb_din  [KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] lb_dout [KERNEL_SIZE-1];

    logic [DATA_WIDTH-1:0] win      [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] win_next [KERNEL_SIZE][KERNEL_SIZE];
    logic [WIN_WIDTH-1:0]  win_flat;

    assign pix_ready = !reset && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;

    // Phase follows the row of the pixel currently being offered.
    always_comb begin
        phase = (row >= ROW_FIRST) ? PHASE_RUN : PHASE_FILL;
    end

    // Windows that would straddle the left image edge (col < K-1) are skipped.
    assign emit = accept && (phase == PHASE_RUN) && (col >= COL_FIRST);

    // Line buffer j holds row (current - 1 - j); each one feeds the next, so
    // the oldest row drops out of the last buffer.
    for (genvar j = 0; j < KERNEL_SIZE - 1; j++) begin : g_lb
        if (j == 0) begin : g_first
            assign lb_din[j] = pix_in;
        end else begin : g_rest
            assign lb_din[j] = lb_dout[j-1];
        end

        feeder_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH),
            .ADDR_WIDTH (COL_WIDTH)
        ) u_lb (
            .clk  (clk),
            .we   (accept),
            .addr (col),
            .din  (lb_din[j]),
            .dout (lb_dout[j])
        );
    end

    // Next window: shift one column left, append the new column top to bottom
    // as oldest line buffer ... newest line buffer, then the incoming pixel.
    always_comb begin
        win_next = win;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                win_next[r][c] = win[r][c+1];
            end
        end
        for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
            win_next[r][KERNEL_SIZE-1] = lb_dout[KERNEL_SIZE-2-r];
        end
        win_next[KERNEL_SIZE-1][KERNEL_SIZE-1] = pix_in;
    end

    // Flatten with element r*K+c in slice r*K+c.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                win_flat[DATA_WIDTH*(r*KERNEL_SIZE+c) +: DATA_WIDTH] = win_next[r][c];
            end
        end
    end

    // Sliding window register advances on every accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win <= win_next;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // One-deep output register; a new window may replace a consumed one in the
    // same cycle, otherwise the held window stays put until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_out   <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_out   <= win_flat;
            win_row   <= row - ROW_FIRST;
            win_col   <= col - COL_FIRST;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    // Pulse the cycle after the last pixel of a frame is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && (row == ROW_LAST) && (col == COL_LAST);
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder on a 5x5 image with a 3x3 kernel. A model
// rebuilds every expected window directly from the pixels it saw accepted.
module tb_conv_window_feeder;

    localparam int DW   = 32;
    localparam int K    = 3;
    localparam int W    = 5;
    localparam int H    = 5;
    localparam int CW   = 3;
    localparam int RW   = 3;
    localparam int WINW = K * K * DW;
    localparam int EW   = WINW + CW + RW;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   pix_in;
    logic            pix_valid;
    logic            pix_ready;
    logic [WINW-1:0] win_out;
    logic            win_valid;
    logic            win_ready;
    logic [RW-1:0]   win_row;
    logic [CW-1:0]   win_col;
    logic            frame_done;

    conv_window_feeder #(
        .DATA_WIDTH  (DW),
        .KERNEL_SIZE (K),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    logic          exp_fd = 1'b0;
    logic          exp_zero = 1'b1;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_windows = 0;
    int            n_frames = 0;
    int            ready_pct = 100;
    int            stall_cnt = 0;

    task automatic check_eq(input string tag, input logic [WINW-1:0] act, input logic [WINW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] build_exp(input int wr, input int wc);
        logic [EW-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                v[DW*(r*K+c) +: DW] = img[wr+r][wc+c];
            end
        end
        v[WINW +: CW]      = CW'(wc);
        v[WINW+CW +: RW]   = RW'(wr);
        return v;
    endfunction

    // Monitor: compares outputs against the model, then updates the model.
    always @(negedge clk) begin
        logic [EW-1:0] front;
        check_eq("win_valid", win_valid, exp_q.size() != 0);
        check_eq("pix_ready", pix_ready, !reset && (exp_q.size() == 0 || win_ready));
        check_eq("frame_done", frame_done, exp_fd);
        if (frame_done === 1'b1) n_frames++;
        if (exp_q.size() != 0) begin
            front = exp_q[0];
            check_eq("win_out", win_out, front[WINW-1:0]);
            check_eq("win_col", win_col, front[WINW +: CW]);
            check_eq("win_row", win_row, front[WINW+CW +: RW]);
            if (win_ready) begin
                void'(exp_q.pop_front());
                n_windows++;
            end
        end else if (exp_zero) begin
            check_eq("reset_win_out", win_out, '0);
            check_eq("reset_win_row", win_row, '0);
            check_eq("reset_win_col", win_col, '0);
        end
        exp_fd = 1'b0;
        if (reset) begin
            exp_q.delete();
            m_row = 0;
            m_col = 0;
            exp_zero = 1'b1;
        end else if (pix_valid && pix_ready) begin
            img[m_row][m_col] = pix_in;
            if (m_row >= K-1 && m_col >= K-1) begin
                exp_q.push_back(build_exp(m_row-(K-1), m_col-(K-1)));
                exp_zero = 1'b0;
            end
            exp_fd = (m_row == H-1 && m_col == W-1);
            if (m_col == W-1) begin
                m_col = 0;
                m_row = (m_row == H-1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        win_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                win_ready = 1'b0;
                stall_cnt--;
            end else begin
                win_ready = ($urandom_range(99) < ready_pct);
            end
        end
    end

    // Offer pixels base+idx for idx = 0..count-1 in raster order.
    task automatic drive_pixels(input int base, input int count, input int valid_pct);
        int idx = 0;
        int waited = 0;
        while (idx < count) begin
            @(posedge clk);
            #1;
            pix_valid = ($urandom_range(99) < valid_pct);
            pix_in    = pix_valid ? DW'(base + idx) : DW'($urandom);
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                idx++;
                waited = 0;
            end else begin
                waited++;
                if (waited > 500) begin
                    check_eq("pix_accept_timeout", 1, 0);
                    return;
                end
            end
        end
    endtask

    // Hold win_ready low for 4 cycles starting at the first held window.
    task automatic stall_once();
        int t = 0;
        while (t < 300) begin
            @(posedge clk);
            #2;
            if (win_valid) break;
            t++;
        end
        if (t >= 300) begin
            check_eq("stall_wait_timeout", 0, 1);
        end else begin
            win_ready = 1'b0;
            stall_cnt = 3;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        ready_pct = 100;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Two continuous frames, back to back.
        drive_pixels(0, W*H, 100);
        drive_pixels(100, W*H, 100);

        // Frame with a 4-cycle consumer stall.
        fork
            drive_pixels(200, W*H, 100);
            stall_once();
        join

        // Partial frame (one window), then reset mid-frame and a fresh frame.
        drive_pixels(300, 13, 100);
        do_reset();
        drive_pixels(400, W*H, 100);

        // Random input gaps and random consumer readiness.
        ready_pct = 70;
        drive_pixels(500, W*H, 50);
        drive_pixels(600, W*H, 50);

        drain();
        check_eq("window_count", n_windows, 55);
        check_eq("frame_count", n_frames, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
